// File: rtl/mem_arbiter_if.sv
// Request/response bus between two requesters (I and D ports), the arbiter and a
// single-port-per-direction word ram with registered read data.
interface mem_arbiter_if #(
    parameter int unsigned AW = 8
);
    logic          i_valid;
    logic [31:0]   i_addr;
    logic          i_ready;
    logic          i_rvalid;
    logic [31:0]   i_rdata;

    logic          d_valid;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [3:0]    d_wstrb;
    logic [31:0]   d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_din;
    logic [3:0]    ram_wen;
    logic [31:0]   ram_dout;

    modport slave (
        input  i_valid, i_addr, d_valid, d_we, d_addr, d_wstrb, d_wdata, ram_dout,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               ram_raddr, ram_waddr, ram_din, ram_wen
    );

    modport master (
        output i_valid, i_addr, d_valid, d_we, d_addr, d_wstrb, d_wdata, ram_dout,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               ram_raddr, ram_waddr, ram_din, ram_wen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one ram: one grant per cycle, alternating
// preference under contention, read data returned one cycle after the grant.
module mem_arbiter #(
    parameter int unsigned depth = 256
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(depth);

    logic          r_pref;     // 0 = D preferred, 1 = I preferred
    logic          r_rsp_v;
    logic          r_rsp_id;   // 1 = response belongs to I port
    logic          w_grant_i;
    logic          w_grant_d;
    logic [AW-1:0] w_i_word;
    logic [AW-1:0] w_d_word;

    assign w_i_word = bus.i_addr[AW+1:2];
    assign w_d_word = bus.d_addr[AW+1:2];

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst) begin
            if (bus.d_valid && (!bus.i_valid || !r_pref)) begin
                w_grant_d = 1'b1;
            end else if (bus.i_valid) begin
                w_grant_i = 1'b1;
            end
        end
    end

    assign bus.i_ready   = w_grant_i;
    assign bus.d_ready   = w_grant_d;
    assign bus.ram_raddr = w_grant_i ? w_i_word : w_d_word;
    assign bus.ram_waddr = w_d_word;
    assign bus.ram_din   = bus.d_wdata;
    assign bus.ram_wen   = (w_grant_d && bus.d_we) ? ~bus.d_wstrb : 4'hF;

    // Gated by rst so a response pending at reset entry never reaches a port.
    assign bus.i_rvalid = r_rsp_v && r_rsp_id && !rst;
    assign bus.d_rvalid = r_rsp_v && !r_rsp_id && !rst;
    assign bus.i_rdata  = bus.ram_dout;
    assign bus.d_rdata  = bus.ram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pref   <= 1'b0;
            r_rsp_v  <= 1'b0;
            r_rsp_id <= 1'b0;
        end else begin
            r_rsp_v  <= w_grant_i || w_grant_d;
            r_rsp_id <= w_grant_i;
            if (w_grant_d) begin
                r_pref <= 1'b1;
            end else if (w_grant_i) begin
                r_pref <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: depth, default 256, word count of the attached ram; AW = $clog2(depth).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 i_valid  input  1  instruction-port read request.
REQ-005 i_addr  input  32  instruction-port byte address.
REQ-006 i_ready  output  1  instruction request granted this cycle.
REQ-007 i_rvalid  output  1  instruction read data valid.
REQ-008 i_rdata  output  32  instruction read data.
REQ-009 d_valid  input  1  data-port request.
REQ-010 d_we  input  1  data-port write (1) / read (0).
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_wstrb  input  4  data-port byte strobes, active-high, bit n = byte n.
REQ-013 d_wdata  input  32  data-port write data.
REQ-014 d_ready  output  1  data request granted this cycle.
REQ-015 d_rvalid  output  1  data response valid (read data or write ack).
REQ-016 d_rdata  output  32  data read data.
REQ-017 ram_raddr  output  AW  ram read word address.
REQ-018 ram_waddr  output  AW  ram write word address.
REQ-019 ram_din  output  32  ram write data.
REQ-020 ram_wen  output  4  ram byte write enables, active-low.
REQ-021 ram_dout  input  32  ram registered read data, one-cycle latency.

Function
REQ-022 Word address = addr[AW+1:2]; addr[1:0] and bits above AW+1 ignored (aliasing wraps).
REQ-023 At most one grant per cycle; i_ready and d_ready combinational from valids and arbitration state, never both 1.
REQ-024 Single requester valid: granted same cycle, no bubble.
REQ-025 Both valid: grant the port named by 1-bit preference register pref (0 = D, 1 = I).
REQ-026 pref updates on every grant to the non-granted port; unchanged in cycles with no grant.
REQ-027 Requester holds valid and all request fields stable until ready; arbiter need not check.
REQ-028 Granted cycle: ram_raddr = granted word address; ram_waddr = d word address when D granted, else don't-care.
REQ-029 ram_wen = ~d_wstrb when D granted with d_we=1; otherwise 4'hF (no write).
REQ-030 ram_din = d_wdata always.
REQ-031 Response pipeline: registers rsp_v, rsp_id; grant in cycle N gives xx_rvalid=1 for exactly one cycle in N+1 on the granted port.
REQ-032 xx_rdata = ram_dout (combinational passthrough); content defined only while xx_rvalid=1.
REQ-033 Write ack: d_rvalid asserted N+1 for writes too; d_rdata = pre-write word (ram read-before-write), testbench ignores it.
REQ-034 Back-to-back: new grant in N+1 allowed while N's response is delivered; full throughput one access per cycle.
REQ-035 d_wstrb=4'h0 write: granted and acked, ram_wen=4'hF.

Reset
REQ-036 While rst=1: i_ready=d_ready=0, ram_wen=4'hF, no grant taken.
REQ-037 Next cycle after rst: i_rvalid=d_rvalid=0, pref=0 (D preferred); pending response from cycle before reset dropped.
REQ-038 ram contents unaffected by rst.

Verification
REQ-039 Reset then i_valid=1, i_addr=0x10, d_valid=0 -> i_ready=1 same cycle, ram_raddr=4, i_rvalid=1 next cycle with i_rdata=mem[4].
REQ-040 Both valid continuously 6 cycles -> grants D,I,D,I,D,I; each rvalid one cycle after grant on correct port.
REQ-041 D write d_addr=0x20, d_wstrb=4'b0101, d_wdata=0xAABBCCDD over mem[8]=0x11223344 -> ram_wen=4'b1010; later read returns 0x11BB33DD.
REQ-042 d_addr=0x404 with depth=256 -> ram_raddr=1 (wrap); d_wstrb=0 write -> ram_wen=4'hF, d_rvalid=1 next cycle.
REQ-043 rst asserted in cycle after an I grant -> i_rvalid stays 0, ready outputs 0, next contested grant goes to D.
REQ-044 Assertions throughout: never i_ready&d_ready; ram_wen!=4'hF only when d_ready&d_we; rvalid count equals grant count per port.
